// File: rtl/uart_tx_fifo_drain.sv
// rtl/uart_tx_fifo_drain.sv - 8N1/8N2 UART transmitter that drains a sync FIFO
// One pop per frame; a launch in the last stop cycle chains frames with no idle gap.
module uart_tx_fifo_drain #(
   parameter int CLKS_PER_BIT = 868,
   parameter int STOP_BITS    = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             fifo_empty,
   input  logic [7:0]       fifo_rd_data,
   output logic             fifo_rd_en,
   input  logic             cts_n,
   output logic             tx,
   output logic             busy,
   output logic [CNT_W-1:0] frames_sent
);
   localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state, state_next;
   logic [BAUD_W-1:0] baud_cnt, baud_next;
   logic [2:0]        bit_idx, bit_next;
   logic [7:0]        shift_reg, shift_next;
   logic              tx_next, busy_next;
   logic [CNT_W-1:0]  frames_next;
   logic              baud_end, last_stop, launch;

   assign baud_end   = (baud_cnt == BAUD_LAST);
   assign last_stop  = (state == STOP) && baud_end && (bit_idx == STOP_LAST);
   assign launch     = ((state == IDLE) || last_stop) && !fifo_empty && !cts_n && rst_n;
   assign fifo_rd_en = launch;

   always_comb begin
      state_next  = state;
      baud_next   = baud_cnt + 1'b1;
      bit_next    = bit_idx;
      shift_next  = shift_reg;
      tx_next     = tx;
      busy_next   = busy;
      frames_next = frames_sent;
      case (state)
         IDLE: begin
            baud_next = '0;
            tx_next   = 1'b1;
            busy_next = 1'b0;
            if (launch) begin
               state_next = START;
               shift_next = fifo_rd_data;
               bit_next   = 3'd0;
               tx_next    = 1'b0;
               busy_next  = 1'b1;
            end
         end
         START: begin
            if (baud_end) begin
               baud_next  = '0;
               bit_next   = 3'd0;
               state_next = DATA;
               tx_next    = shift_reg[0];
            end
         end
         DATA: begin
            // shift_reg[0] is always the bit currently on the line
            if (baud_end) begin
               baud_next = '0;
               if (bit_idx == 3'd7) begin
                  state_next = STOP;
                  bit_next   = 3'd0;
                  tx_next    = 1'b1;
               end else begin
                  bit_next   = bit_idx + 3'd1;
                  shift_next = {1'b0, shift_reg[7:1]};
                  tx_next    = shift_reg[1];
               end
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_next = '0;
               if (bit_idx == STOP_LAST) begin
                  frames_next = frames_sent + 1'b1;
                  bit_next    = 3'd0;
                  if (launch) begin
                     state_next = START;
                     shift_next = fifo_rd_data;
                     tx_next    = 1'b0;
                  end else begin
                     state_next = IDLE;
                     tx_next    = 1'b1;
                     busy_next  = 1'b0;
                  end
               end else begin
                  bit_next = bit_idx + 3'd1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            tx_next    = 1'b1;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         baud_cnt    <= '0;
         bit_idx     <= 3'd0;
         shift_reg   <= 8'h00;
         tx          <= 1'b1;
         busy        <= 1'b0;
         frames_sent <= '0;
      end else begin
         state       <= state_next;
         baud_cnt    <= baud_next;
         bit_idx     <= bit_next;
         shift_reg   <= shift_next;
         tx          <= tx_next;
         busy        <= busy_next;
         frames_sent <= frames_next;
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb/tb_uart_tx_fifo_drain.sv - scoreboard bench for uart_tx_fifo_drain
// dut0: 8N1, 16-bit counter; dut1: 8N2, 4-bit counter so the wrap is reachable.
module tb_uart_tx_fifo_drain;
   localparam int CPB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [2];
   logic        cts_n [2];
   logic        fifo_empty [2] = '{1'b1, 1'b1};
   logic [7:0]  rd_data [2]    = '{8'h00, 8'h00};
   logic        rd_en [2];
   logic        tx_s [2];
   logic        busy_s [2];
   logic [15:0] fs0;
   logic [3:0]  fs1;

   logic [7:0]  fq [2][$];
   logic [7:0]  expq [2][$];
   int          popt [2][$];
   int          pops [2]     = '{0, 0};
   int          busy_cnt [2] = '{0, 0};
   int          fcount [2]   = '{0, 0};
   int          cyc = 0;
   int          nchecks = 0;
   int          nerrors = 0;

   uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .CNT_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n[0]), .fifo_empty(fifo_empty[0]), .fifo_rd_data(rd_data[0]),
      .fifo_rd_en(rd_en[0]), .cts_n(cts_n[0]), .tx(tx_s[0]), .busy(busy_s[0]), .frames_sent(fs0));

   uart_tx_fifo_drain #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .CNT_W(4)) dut1 (
      .clk(clk), .rst_n(rst_n[1]), .fifo_empty(fifo_empty[1]), .fifo_rd_data(rd_data[1]),
      .fifo_rd_en(rd_en[1]), .cts_n(cts_n[1]), .tx(tx_s[1]), .busy(busy_s[1]), .frames_sent(fs1));

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      nchecks++;
      if (got !== want) begin
         nerrors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   function automatic logic [31:0] fs(input int d);
      return (d == 0) ? 32'(fs0) : 32'(fs1);
   endfunction

   function automatic logic [31:0] fmask(input int d);
      return (d == 0) ? 32'h0000_FFFF : 32'h0000_000F;
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (busy_s[d]) busy_cnt[d]++;
         if (rd_en[d]) chk($sformatf("pop_guard%0d", d), fifo_empty[d] | cts_n[d], 0);
      end
   end

   // FIFO model: pops on the strobe, presents the new head after the edge
   task automatic popper(input int d);
      bit popped;
      forever begin
         @(posedge clk);
         popped = 0;
         if (rd_en[d]) begin
            chk($sformatf("pop_nonempty%0d", d), fq[d].size() != 0, 1);
            if (fq[d].size() != 0) begin
               expq[d].push_back(fq[d].pop_front());
               popped = 1;
            end
            pops[d]++;
            popt[d].push_back(cyc);
         end
         fifo_empty[d] <= (fq[d].size() == 0);
         rd_data[d]    <= (fq[d].size() != 0) ? fq[d][0] : 8'h00;
         if (popped) begin
            #1;
            chk($sformatf("pop_to_start_tx%0d", d), tx_s[d], 0);
            chk($sformatf("pop_to_start_busy%0d", d), busy_s[d], 1);
         end
      end
   endtask

   // Line monitor: checks every cycle of a frame against the ideal waveform
   task automatic monitor(input int d);
      int         len;
      logic [7:0] want, got;
      logic       line_ok, aborted, ebit;
      len = (9 + ((d == 0) ? 1 : 2)) * CPB;
      forever begin
         @(negedge clk);
         if (!rst_n[d]) begin
            fcount[d] = 0;
         end else if (tx_s[d] === 1'b0) begin
            chk($sformatf("frame_has_pop%0d", d), expq[d].size() != 0, 1);
            want = (expq[d].size() != 0) ? expq[d].pop_front() : 8'h00;
            got = 8'h00;
            line_ok = 1;
            aborted = 0;
            for (int k = 0; k < len; k++) begin
               if (k > 0) @(negedge clk);
               if (!rst_n[d]) begin
                  aborted = 1;
                  break;
               end
               if (k < CPB) ebit = 1'b0;
               else if (k < 9 * CPB) ebit = want[k / CPB - 1];
               else ebit = 1'b1;
               if (tx_s[d] !== ebit || busy_s[d] !== 1'b1) line_ok = 0;
               if (k >= CPB && k < 9 * CPB && (k % CPB) == CPB / 2) got[k / CPB - 1] = tx_s[d];
            end
            if (aborted) begin
               fcount[d] = 0;
            end else begin
               chk($sformatf("frame_line%0d", d), line_ok, 1);
               chk($sformatf("frame_byte%0d", d), got, want);
               fcount[d]++;
               @(posedge clk);
               #1;
               chk($sformatf("frames_sent%0d", d), fs(d), fcount[d] & fmask(d));
            end
         end
      end
   endtask

   task automatic wait_idle(input int d, input int budget);
      int n = 0;
      do begin
         step(1);
         n++;
      end while ((fq[d].size() != 0 || expq[d].size() != 0 || busy_s[d] || !fifo_empty[d]) && n < budget);
      chk($sformatf("idle_in_time%0d", d), n < budget, 1);
   endtask

   initial begin
      #500000;
      nerrors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

   initial begin
      int p, b, n;
      rst_n = '{1'b0, 1'b0};
      cts_n = '{1'b0, 1'b0};
      fork
         popper(0);
         popper(1);
         monitor(0);
         monitor(1);
      join_none

      // reset held with a non-empty FIFO
      fq[0].push_back(8'hA5);
      for (int i = 0; i < 3; i++) begin
         step(1);
         chk("reset_tx", tx_s[0], 1);
         chk("reset_busy", busy_s[0], 0);
         chk("reset_frames", fs(0), 0);
         chk("reset_rd_en", rd_en[0], 0);
      end
      p = pops[0];
      rst_n = '{1'b1, 1'b1};

      // single byte 0xA5
      wait_idle(0, 200);
      chk("t2_one_pop", pops[0] - p, 1);
      chk("t2_frames", fs(0), 1);
      chk("t2_busy_after", busy_s[0], 0);

      // back-to-back 0x00, 0xFF, 0x55
      b = busy_cnt[0];
      popt[0].delete();
      fq[0].push_back(8'h00);
      fq[0].push_back(8'hFF);
      fq[0].push_back(8'h55);
      wait_idle(0, 400);
      chk("t3_pops", popt[0].size(), 3);
      if (popt[0].size() == 3) begin
         chk("t3_gap1", popt[0][1] - popt[0][0], 40);
         chk("t3_gap2", popt[0][2] - popt[0][1], 40);
      end
      chk("t3_busy_cycles", busy_cnt[0] - b, 120);
      chk("t3_frames", fs(0), 4);

      // clear-to-send gating
      cts_n[0] = 1'b1;
      p = pops[0];
      fq[0].push_back(8'h3C);
      step(10);
      chk("t4_held_pops", pops[0] - p, 0);
      chk("t4_held_tx", tx_s[0], 1);
      cts_n[0] = 1'b0;
      step(1);
      chk("t4_pop_on_cts", pops[0] - p, 1);
      step(15);
      cts_n[0] = 1'b1;
      wait_idle(0, 200);
      cts_n[0] = 1'b0;
      chk("t4_frames", fs(0), 5);

      // reset in bit 4 of a frame
      p = pops[0];
      fq[0].push_back(8'h5A);
      n = 0;
      while (pops[0] == p && n < 100) begin
         step(1);
         n++;
      end
      chk("t5_pop_seen", pops[0] - p, 1);
      step(21);
      rst_n[0] = 1'b0;
      fq[0].push_back(8'hC3);
      @(posedge clk);
      #1;
      chk("t5_reset_tx", tx_s[0], 1);
      chk("t5_reset_busy", busy_s[0], 0);
      chk("t5_reset_frames", fs(0), 0);
      #1;
      rst_n[0] = 1'b1;
      wait_idle(0, 200);
      chk("t5_frames_after", fs(0), 1);

      // randomized traffic with random clear-to-send
      for (int i = 0; i < 25; i++) begin
         cts_n[0] = ($urandom_range(0, 3) == 0);
         step($urandom_range(1, 50));
         fq[0].push_back(8'($urandom));
      end
      cts_n[0] = 1'b0;
      wait_idle(0, 3000);
      chk("rand_frames", fs(0), 26);

      // two stop bits, byte 0x81
      b = busy_cnt[1];
      fq[1].push_back(8'h81);
      wait_idle(1, 200);
      chk("t6_busy_cycles", busy_cnt[1] - b, 44);
      chk("t6_frames", fs(1), 1);

      // counter wrap on the narrow counter
      for (int i = 0; i < 15; i++) fq[1].push_back(8'($urandom));
      wait_idle(1, 1000);
      chk("t7_wrap", fs(1), 0);

      step(5);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end
endmodule
